// File: rtl/tft_frame_sequencer.sv
// Sequences one TFT frame: CASET/PASET/RAMWR command bytes, then gates width*height pixel transfers.
// Optional inter-frame idle gap is built when TFT_FRAME_DELAY_EN is defined.
module tft_frame_sequencer #(
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_PASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_width,
    input  logic [15:0] i_height,
    input  logic [23:0] i_frame_delay,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_data,
    output logic        o_cmd_dc,
    input  logic        i_cmd_rdy,
    output logic        o_pixel_en,
    input  logic        i_pixel_rdy,
    input  logic        i_pixel_stb,
    output logic        o_frame_done,
    output logic        o_busy,
    output logic [31:0] o_frame_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_DELAY  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t      state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic [15:0] width_r, width_s;
    logic [15:0] height_r, height_s;
    logic [31:0] total_r, total_s;
    logic [31:0] pix_r, pix_s;
    logic        start_ok_s;
    logic        load_s;
    logic [8:0]  cmd_word_s;
`ifdef TFT_FRAME_DELAY_EN
    logic [23:0] dly_r, dly_s;
`else
    logic        unused_delay_s;
    assign unused_delay_s = ^i_frame_delay;
`endif

    // Command byte table: {dc, data}; window starts at 0 and ends at dimension-1.
    function automatic logic [8:0] cmd_byte(input logic [3:0] idx, input logic [15:0] w,
                                            input logic [15:0] h);
        logic [15:0] wm1;
        logic [15:0] hm1;
        wm1 = w - 16'd1;
        hm1 = h - 16'd1;
        case (idx)
            4'd0:    cmd_byte = {1'b0, CMD_CASET};
            4'd3:    cmd_byte = {1'b1, wm1[15:8]};
            4'd4:    cmd_byte = {1'b1, wm1[7:0]};
            4'd5:    cmd_byte = {1'b0, CMD_PASET};
            4'd8:    cmd_byte = {1'b1, hm1[15:8]};
            4'd9:    cmd_byte = {1'b1, hm1[7:0]};
            4'd10:   cmd_byte = {1'b0, CMD_RAMWR};
            default: cmd_byte = {1'b1, 8'h00};
        endcase
    endfunction

    // Next-state, command index, pixel count and frame-start dimension latching.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        pix_s      = pix_r;
        load_s     = 1'b0;
`ifdef TFT_FRAME_DELAY_EN
        dly_s      = dly_r;
`endif
        start_ok_s = i_enable && (i_width != 16'd0) && (i_height != 16'd0);
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_CMD;
                    load_s  = 1'b1;
                    idx_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (o_cmd_valid && i_cmd_rdy) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_STREAM;
                        pix_s   = 32'd0;
                    end else begin
                        idx_s = idx_r + 4'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_STREAM: begin
                if (i_pixel_stb && i_pixel_rdy && o_pixel_en) begin
                    if (pix_r == total_r - 32'd1) begin
                        state_s = ST_DONE;
                    end else begin
                        pix_s = pix_r + 32'd1;
                    end
                end else begin
                    pix_s = pix_r;
                end
            end
            ST_DONE: begin
`ifdef TFT_FRAME_DELAY_EN
                if (i_enable) begin
                    state_s = ST_DELAY;
                    dly_s   = i_frame_delay;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (start_ok_s) begin
                    state_s = ST_CMD;
                    load_s  = 1'b1;
                    idx_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
`ifdef TFT_FRAME_DELAY_EN
            ST_DELAY: begin
                if (dly_r > 24'd1) begin
                    dly_s = dly_r - 24'd1;
                end else if (start_ok_s) begin
                    state_s = ST_CMD;
                    load_s  = 1'b1;
                    idx_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        width_s    = load_s ? i_width : width_r;
        height_s   = load_s ? i_height : height_r;
        total_s    = load_s ? (32'(i_width) * 32'(i_height)) : total_r;
        cmd_word_s = cmd_byte(idx_s, width_s, height_s);
    end

    // State, datapath and registered outputs (outputs follow the next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= 4'd0;
            width_r       <= 16'd0;
            height_r      <= 16'd0;
            total_r       <= 32'd0;
            pix_r         <= 32'd0;
`ifdef TFT_FRAME_DELAY_EN
            dly_r         <= 24'd0;
`endif
            o_cmd_valid   <= 1'b0;
            o_cmd_data    <= 8'd0;
            o_cmd_dc      <= 1'b0;
            o_pixel_en    <= 1'b0;
            o_frame_done  <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_count <= 32'd0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            width_r       <= width_s;
            height_r      <= height_s;
            total_r       <= total_s;
            pix_r         <= pix_s;
`ifdef TFT_FRAME_DELAY_EN
            dly_r         <= dly_s;
`endif
            o_cmd_valid   <= (state_s == ST_CMD);
            o_cmd_data    <= (state_s == ST_CMD) ? cmd_word_s[7:0] : 8'd0;
            o_cmd_dc      <= (state_s == ST_CMD) ? cmd_word_s[8] : 1'b0;
            o_pixel_en    <= (state_s == ST_STREAM);
            o_frame_done  <= (state_s == ST_DONE);
            o_busy        <= (state_s != ST_IDLE);
            o_frame_count <= (state_s == ST_DONE) ? (o_frame_count + 32'd1) : o_frame_count;
        end
    end

endmodule
